// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : if_prefetch_unit
// Purpose : MIPS fetch engine with req/gnt/rvalid IMEM port and prefetch queue
// Revision: 1.0
// ============================================================================
module if_prefetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h8000_0180)
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [DATA_W-1:0]          imem_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       exception,
  input  logic                       id_hold,
  output logic                       if_valid,
  output logic [DATA_W-1:0]          if_instr,
  output logic [ADDR_W-1:0]          if_pc,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc, r_pend_pc, w_target;
  logic [ADDR_W-1:0] r_q_pc   [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_flush, w_push, w_deq, w_gnt_ok;
  logic              w_space_idle, w_space_push;

  assign w_flush  = redirect_valid | exception;
  assign w_target = exception ? EXC_VECTOR : {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_gnt_ok = (r_state == S_REQ) & imem_gnt;
  assign w_push   = (r_state == S_WAIT) & imem_rvalid & ~w_flush;
  assign w_deq    = if_valid & ~id_hold & ~w_flush;

  // Space uses the registered count only; a same-cycle dequeue does not help.
  assign w_space_idle = r_count < c_DEPTH;
  assign w_space_push = (r_count + CW'(1)) < c_DEPTH;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_flush || w_space_idle) w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_flush)       w_state_nxt = imem_gnt ? S_DROP : S_REQ;
        else if (imem_gnt) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)   w_state_nxt = (w_flush || w_space_push) ? S_REQ : S_IDLE;
        else if (w_flush)  w_state_nxt = S_DROP;
      end
      // Once the dropped response lands nothing is outstanding, even if a new
      // flush arrives in the same cycle, so fetching can restart.
      S_DROP: if (imem_rvalid) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (r_state == S_REQ);
    imem_addr = r_fetch_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= RESET_PC;
    end else begin
      if (w_gnt_ok) r_pend_pc <= r_fetch_pc;
      if (w_flush)       r_fetch_pc <= w_target;
      else if (w_gnt_ok) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_deq)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wptr]   <= r_pend_pc;
      r_q_data[r_wptr] <= imem_rdata;
    end
  end

  assign q_count  = r_count;
  assign if_valid = (r_count != '0);
  assign if_instr = if_valid ? r_q_data[r_rptr] : '0;
  assign if_pc    = if_valid ? (r_q_pc[r_rptr] + ADDR_W'(4)) : '0;

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`default_nettype none
// Directed bench for if_prefetch_unit; a small in-bench memory answers one
// cycle after each grant with word {16'hC0DE, addr[15:0]}.
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, exception, id_hold;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic [2:0]  q_count;

  logic        wr_req, wr_valid;
  logic [31:0] wr_addr, wr_instr, wr_pc;
  logic [2:0]  wr_count;
  logic        c_one  = 1'b1;
  logic        c_zero = 1'b0;
  logic [31:0] c_wdata = 32'h1234_5678;
  logic [31:0] c_wzero = 32'h0;

  int          n_cmp = 0, n_fail = 0, n_gnt = 0;
  logic        gnt_en, rv_en, pend;
  logic [31:0] pend_addr;

  always #5 clk = ~clk;

  if_prefetch_unit u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exception(exception), .id_hold(id_hold), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .q_count(q_count)
  );

  if_prefetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst), .imem_req(wr_req), .imem_addr(wr_addr),
    .imem_gnt(c_one), .imem_rvalid(c_one), .imem_rdata(c_wdata),
    .redirect_valid(c_zero), .redirect_pc(c_wzero),
    .exception(c_zero), .id_hold(c_zero), .if_valid(wr_valid),
    .if_instr(wr_instr), .if_pc(wr_pc), .q_count(wr_count)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic tick();
    logic g, s;
    logic [31:0] a;
    imem_gnt    = gnt_en && imem_req;
    imem_rvalid = rv_en && pend;
    imem_rdata  = mem(pend_addr);
    g = imem_gnt; s = imem_rvalid; a = imem_addr;
    @(posedge clk); #1;
    if (s) pend = 1'b0;
    if (g) begin pend = 1'b1; pend_addr = a; n_gnt++; end
  endtask

  task automatic clear_inputs();
    gnt_en = 1'b1; rv_en = 1'b1; id_hold = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; exception = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
  endtask

  // Leaves the bench one step after rst release (cycle 0).
  task automatic do_reset();
    clear_inputs();
    pend = 1'b0; pend_addr = '0; n_gnt = 0;
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    pend = 1'b0; pend_addr = '0;
    rst = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_instr !== 32'h0 || if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_head: got %h/%h want 0/0", if_instr, if_pc); end
    n_cmp++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", q_count); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_free_run();
    do_reset();
    tick();  // cycle 1
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL fr_c1: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    tick();  // cycle 2
    n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL fr_c2: got req=%b valid=%b want 0/0", imem_req, if_valid); end
    tick();  // cycle 3
    n_cmp++; if (if_valid !== 1'b1 || if_instr !== 32'hC0DE_0000 || if_pc !== 32'h4) begin n_fail++; $display("FAIL fr_c3_head: got %b %h %h want 1 c0de0000 4", if_valid, if_instr, if_pc); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL fr_c3_req: got req=%b addr=%h want 1/4", imem_req, imem_addr); end
    tick(); tick();  // cycle 5
    n_cmp++; if (if_instr !== 32'hC0DE_0004 || if_pc !== 32'h8 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL fr_c5: got %h %h %h want c0de0004 8 8", if_instr, if_pc, imem_addr); end
    tick(); tick();  // cycle 7
    n_cmp++; if (if_instr !== 32'hC0DE_0008 || if_pc !== 32'hC) begin n_fail++; $display("FAIL fr_c7: got %h %h want c0de0008 c", if_instr, if_pc); end
  endtask

  task automatic test_full_queue();
    do_reset();
    id_hold = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (n_gnt !== 4) begin n_fail++; $display("FAIL full_fetches: got %0d want 4", n_gnt); end
    n_cmp++; if (q_count !== 3'd4 || imem_req !== 1'b0) begin n_fail++; $display("FAIL full_state: got count=%0d req=%b want 4/0", q_count, imem_req); end
    n_cmp++; if (if_instr !== 32'hC0DE_0000 || if_pc !== 32'h4) begin n_fail++; $display("FAIL full_head: got %h %h want c0de0000 4", if_instr, if_pc); end
    id_hold = 1'b0;
    tick();
    n_cmp++; if (if_instr !== 32'hC0DE_0004 || q_count !== 3'd3) begin n_fail++; $display("FAIL full_drain1: got %h cnt=%0d want c0de0004 3", if_instr, q_count); end
    tick();
    n_cmp++; if (if_instr !== 32'hC0DE_0008) begin n_fail++; $display("FAIL full_drain2: got %h want c0de0008", if_instr); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL full_resume: got req=%b addr=%h want 1/10", imem_req, imem_addr); end
    tick();
    n_cmp++; if (if_instr !== 32'hC0DE_000C) begin n_fail++; $display("FAIL full_drain3: got %h want c0de000c", if_instr); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    rv_en = 1'b0;
    tick(); tick();  // cycle 2, fetch of 0x0 outstanding
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0; redirect_pc = '0;
    n_cmp++; if (imem_req !== 1'b0 || q_count !== 3'd0) begin n_fail++; $display("FAIL rd_drop: got req=%b cnt=%0d want 0/0", imem_req, q_count); end
    rv_en = 1'b1;
    tick();  // late word arrives
    n_cmp++; if (q_count !== 3'd0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rd_discard: got cnt=%0d valid=%b want 0/0", q_count, if_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL rd_target: got req=%b addr=%h want 1/100", imem_req, imem_addr); end
    tick(); tick();
    n_cmp++; if (if_instr !== 32'hC0DE_0100 || if_pc !== 32'h104) begin n_fail++; $display("FAIL rd_first: got %h %h want c0de0100 104", if_instr, if_pc); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    id_hold = 1'b1;
    tick(); tick(); tick(); tick();  // cycle 4: one queued, fetch of 0x4 in WAIT
    n_cmp++; if (q_count !== 3'd1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL sim_pre: got cnt=%0d addr=%h want 1/8", q_count, imem_addr); end
    id_hold = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; exception = 1'b1;
    tick();
    redirect_valid = 1'b0; exception = 1'b0; redirect_pc = '0;
    n_cmp++; if (q_count !== 3'd0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL sim_empty: got cnt=%0d valid=%b want 0/0", q_count, if_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0180) begin n_fail++; $display("FAIL sim_exc: got req=%b addr=%h want 1/80000180", imem_req, imem_addr); end
    gnt_en = 1'b0;
    tick();
    n_cmp++; if (q_count !== 3'd0 || imem_addr !== 32'h8000_0180) begin n_fail++; $display("FAIL sim_nopush: got cnt=%0d addr=%h want 0/80000180", q_count, imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    n_cmp++; if (wr_req !== 1'b1 || wr_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first: got req=%b addr=%h want 1/fffffffc", wr_req, wr_addr); end
    tick(); tick();
    n_cmp++; if (wr_addr !== 32'h0 || wr_valid !== 1'b1 || wr_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_second: got addr=%h valid=%b pc=%h want 0/1/0", wr_addr, wr_valid, wr_pc); end
    n_cmp++; if (wr_instr !== 32'h1234_5678 || wr_count !== 3'd1) begin n_fail++; $display("FAIL wrap_head: got %h cnt=%0d want 12345678/1", wr_instr, wr_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    id_hold = 1'b1;
    tick(); tick(); tick(); tick();  // cycle 4: WAIT on 0x4, one queued
    n_cmp++; if (q_count !== 3'd1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL ar_pre: got cnt=%0d addr=%h want 1/8", q_count, imem_addr); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (q_count !== 3'd0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL ar_queue: got cnt=%0d valid=%b want 0/0", q_count, if_valid); end
    n_cmp++; if (if_instr !== 32'h0 || if_pc !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL ar_outs: got %h %h %h %b want 0 0 0 0", if_instr, if_pc, imem_addr, imem_req); end
    @(posedge clk); #1;
    rst = 1'b1;
    tick();  // stale response delivered while idle
    n_cmp++; if (q_count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_restart: got cnt=%0d req=%b addr=%h want 0/1/0", q_count, imem_req, imem_addr); end
    tick(); tick();
    n_cmp++; if (q_count !== 3'd1 || if_instr !== 32'hC0DE_0000) begin n_fail++; $display("FAIL ar_first: got cnt=%0d instr=%h want 1/c0de0000", q_count, if_instr); end
  endtask

  initial begin
    clear_inputs();
    pend = 1'b0; pend_addr = '0;
    #1;
    test_reset();
    test_free_run();
    test_full_queue();
    test_redirect_wait();
    test_simultaneous();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
